// File: rtl/div_unit.sv
// div_unit: multi-cycle radix-2 restoring integer divider for the execute stage.
// Handles div/divu, one quotient bit per clock, with divide-by-zero and
// pipeline-flush (annul) support. result_o = {remainder, quotient}.
module div_unit #(
  parameter int DIV_WIDTH = 32,
  parameter int CNT_WIDTH = 6
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   signed_div_i,
  input  logic [DIV_WIDTH-1:0]   opdata1_i,
  input  logic [DIV_WIDTH-1:0]   opdata2_i,
  input  logic                   start_i,
  input  logic                   annul_i,
  output logic [2*DIV_WIDTH-1:0] result_o,
  output logic                   ready_o,
  output logic                   busy_o
);

  typedef enum logic [1:0] {
    DIV_FREE   = 2'b00,
    DIV_BYZERO = 2'b01,
    DIV_ON     = 2'b10,
    DIV_END    = 2'b11
  } state_t;

  localparam logic [CNT_WIDTH-1:0] LP_LAST = CNT_WIDTH'(DIV_WIDTH);

  state_t                 r_state;
  logic [CNT_WIDTH-1:0]   r_cnt;
  logic [DIV_WIDTH-1:0]   r_rem;        // partial remainder
  logic [DIV_WIDTH-1:0]   r_quo;        // dividend bits shifting out, quotient bits shifting in
  logic [DIV_WIDTH-1:0]   r_divisor;    // divisor magnitude
  logic                   r_neg_dividend;
  logic                   r_neg_quot;
  logic [2*DIV_WIDTH-1:0] r_res;        // sign-corrected result waiting in DIV_END

  // Operand magnitudes and signs, only meaningful for signed requests.
  logic                 w_op1_neg;
  logic                 w_op2_neg;
  logic [DIV_WIDTH-1:0] w_op1_mag;
  logic [DIV_WIDTH-1:0] w_op2_mag;

  assign w_op1_neg = signed_div_i & opdata1_i[DIV_WIDTH-1];
  assign w_op2_neg = signed_div_i & opdata2_i[DIV_WIDTH-1];
  assign w_op1_mag = w_op1_neg ? -opdata1_i : opdata1_i;
  assign w_op2_mag = w_op2_neg ? -opdata2_i : opdata2_i;

  // One restoring step: shift the next dividend bit into the remainder and
  // trial-subtract; the extra top bit of the difference is the borrow.
  logic [DIV_WIDTH:0]   w_shifted;
  logic [DIV_WIDTH:0]   w_diff;
  logic                 w_fits;
  logic [DIV_WIDTH-1:0] w_rem_next;
  logic [DIV_WIDTH-1:0] w_quo_next;

  assign w_shifted  = {r_rem, r_quo[DIV_WIDTH-1]};
  assign w_diff     = w_shifted - {1'b0, r_divisor};
  assign w_fits     = ~w_diff[DIV_WIDTH];
  assign w_rem_next = w_fits ? w_diff[DIV_WIDTH-1:0] : w_shifted[DIV_WIDTH-1:0];
  assign w_quo_next = {r_quo[DIV_WIDTH-2:0], w_fits};

  // Sign correction: quotient follows the XOR of operand signs, remainder
  // follows the dividend (truncation toward zero). -2^(W-1) / -1 wraps
  // naturally to 2^(W-1) in the quotient, with no trap.
  logic [DIV_WIDTH-1:0] w_quo_fix;
  logic [DIV_WIDTH-1:0] w_rem_fix;

  assign w_quo_fix = r_neg_quot     ? -r_quo : r_quo;
  assign w_rem_fix = r_neg_dividend ? -r_rem : r_rem;

  // busy_o is decoded straight from the state register.
  assign busy_o = (r_state == DIV_BYZERO) || (r_state == DIV_ON);

  // Divider FSM: operand capture, iteration, result staging and handshake.
  // NOTE: all state and registered outputs use non-blocking assignments so
  // every register samples the pre-edge values of its neighbours.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state        <= DIV_FREE;
      r_cnt          <= '0;
      r_rem          <= '0;
      r_quo          <= '0;
      r_divisor      <= '0;
      r_neg_dividend <= 1'b0;
      r_neg_quot     <= 1'b0;
      r_res          <= '0;
      result_o       <= '0;
      ready_o        <= 1'b0;
    end else begin
      case (r_state)
        DIV_FREE: begin
          if (start_i && !annul_i) begin
            if (opdata2_i == '0) begin
              r_state <= DIV_BYZERO;
            end else begin
              r_state        <= DIV_ON;
              r_cnt          <= '0;
              r_rem          <= '0;
              r_quo          <= w_op1_mag;
              r_divisor      <= w_op2_mag;
              r_neg_dividend <= w_op1_neg;
              r_neg_quot     <= w_op1_neg ^ w_op2_neg;
            end
          end
        end
        DIV_BYZERO: begin
          r_state <= DIV_END;
          r_res   <= '0;
        end
        DIV_ON: begin
          if (annul_i) begin
            r_state <= DIV_FREE;
            r_cnt   <= '0;
          end else if (r_cnt != LP_LAST) begin
            r_rem <= w_rem_next;
            r_quo <= w_quo_next;
            r_cnt <= r_cnt + 1'b1;
          end else begin
            r_state <= DIV_END;
            r_cnt   <= '0;
            r_res   <= {w_rem_fix, w_quo_fix};
          end
        end
        DIV_END: begin
          if (start_i && !annul_i) begin
            result_o <= r_res;
            ready_o  <= 1'b1;
          end else begin
            r_state  <= DIV_FREE;
            result_o <= '0;
            ready_o  <= 1'b0;
          end
        end
        default: r_state <= DIV_FREE;
      endcase
    end
  end

endmodule

// File: tb/tb_div_unit.sv
// tb_div_unit: directed and randomized checks of div_unit against an
// arithmetic reference model (64-bit integer division, truncation to zero).
module tb_div_unit;

  localparam int W = 32;

  logic           clk;
  logic           rst;
  logic           signed_div;
  logic [W-1:0]   opdata1;
  logic [W-1:0]   opdata2;
  logic           start;
  logic           annul;
  logic [2*W-1:0] result;
  logic           ready;
  logic           busy;

  int n_checks = 0;
  int n_pass   = 0;

  div_unit #(.DIV_WIDTH(W), .CNT_WIDTH(6)) dut (
    .clk          (clk),
    .rst          (rst),
    .signed_div_i (signed_div),
    .opdata1_i    (opdata1),
    .opdata2_i    (opdata2),
    .start_i      (start),
    .annul_i      (annul),
    .result_o     (result),
    .ready_o      (ready),
    .busy_o       (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  // Reference: plain 64-bit integer division; {remainder, quotient}, zero on /0.
  function automatic logic [63:0] ref_div(input logic [W-1:0] a, input logic [W-1:0] b,
                                          input logic s);
    longint na, nb, q, r;
    if (b == '0) return 64'd0;
    na = s ? longint'($signed(a)) : longint'(a);
    nb = s ? longint'($signed(b)) : longint'(b);
    q  = na / nb;
    r  = na % nb;
    return {r[31:0], q[31:0]};
  endfunction

  // One full request/response handshake with latency, busy and hold checks.
  // Operands are scrambled while the divider runs; they must be ignored.
  task automatic do_div(input logic [W-1:0] a, input logic [W-1:0] b, input logic s,
                        input logic [63:0] exp, input string tag);
    int edges    = 0;
    int busy_cnt = 0;
    @(negedge clk);
    opdata1 = a; opdata2 = b; signed_div = s; start = 1'b1;
    do begin
      @(posedge clk);
      @(negedge clk);
      edges++;
      if (busy) busy_cnt++;
      opdata1 = $urandom; opdata2 = $urandom; signed_div = 1'($urandom_range(0, 1));
    end while (!ready && edges < 80);
    check({tag, " latency"}, 64'(edges - 1), (b == '0) ? 64'd2 : 64'(W + 2));
    check({tag, " busy cycles"}, 64'(busy_cnt), (b == '0) ? 64'd1 : 64'(W + 1));
    check({tag, " result"}, result, exp);
    repeat (2) @(negedge clk);
    check({tag, " ready held"}, 64'(ready), 64'd1);
    check({tag, " result held"}, result, exp);
    start = 1'b0;
    @(negedge clk);
    check({tag, " ready drop"}, 64'(ready), 64'd0);
    check({tag, " result clear"}, result, 64'd0);
  endtask

  initial begin
    logic [W-1:0] ra, rb;
    logic         rs;
    int           sel;
    int           ready_seen;

    rst = 1'b0; start = 1'b0; annul = 1'b0; signed_div = 1'b0;
    opdata1 = '0; opdata2 = '0;
    repeat (3) @(negedge clk);
    check("reset result", result, 64'd0);
    check("reset ready", 64'(ready), 64'd0);
    check("reset busy", 64'(busy), 64'd0);
    rst = 1'b1;

    // Directed cases from the expected-value table.
    do_div(32'd100, 32'd7, 1'b0, 64'h00000002_0000000E, "u100/7");
    do_div(32'hFFFFFFF9, 32'h2, 1'b1, 64'hFFFFFFFF_FFFFFFFD, "s-7/2");
    do_div(32'hFFFFFFF9, 32'h2, 1'b0, 64'h00000001_7FFFFFFC, "u-7/2");
    do_div(32'h1234, 32'h0, 1'b0, 64'h0, "div0");
    do_div(32'h80000000, 32'hFFFFFFFF, 1'b1, 64'h00000000_80000000, "smin/-1");
    do_div(32'hFFFFFFFF, 32'h1, 1'b0, 64'h00000000_FFFFFFFF, "umax/1");
    do_div(32'd7, 32'hFFFFFFFE, 1'b1, 64'h00000001_FFFFFFFD, "s7/-2");

    // Annul on the 10th DIV_ON cycle.
    @(negedge clk);
    opdata1 = 32'd1000; opdata2 = 32'd3; signed_div = 1'b0; start = 1'b1;
    @(posedge clk);
    repeat (9) @(posedge clk);
    @(negedge clk);
    check("annul busy before", 64'(busy), 64'd1);
    annul = 1'b1; start = 1'b0;
    @(negedge clk);
    check("annul busy after", 64'(busy), 64'd0);
    check("annul result", result, 64'd0);
    annul = 1'b0;
    ready_seen = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (ready) ready_seen++;
    end
    check("annul no ready", 64'(ready_seen), 64'd0);
    do_div(32'd9, 32'd3, 1'b0, 64'h00000000_00000003, "9/3 after annul");

    // Asynchronous reset between edges in the middle of DIV_ON.
    @(negedge clk);
    opdata1 = 32'd50000; opdata2 = 32'd7; signed_div = 1'b0; start = 1'b1;
    repeat (10) @(posedge clk);
    #2;
    check("pre-reset busy", 64'(busy), 64'd1);
    rst = 1'b0;
    #1;
    check("async rst busy", 64'(busy), 64'd0);
    check("async rst ready", 64'(ready), 64'd0);
    check("async rst result", result, 64'd0);
    start = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    do_div(32'd50, 32'd5, 1'b0, 64'h00000000_0000000A, "50/5 after rst");

    // Randomized operands checked against the arithmetic model.
    for (int i = 0; i < 16; i++) begin
      ra  = $urandom;
      sel = $urandom_range(0, 3);
      case (sel)
        0:       rb = '0;
        1:       rb = W'($urandom_range(1, 15));
        2:       rb = -W'($urandom_range(1, 15));
        default: rb = $urandom;
      endcase
      rs = 1'($urandom_range(0, 1));
      do_div(ra, rb, rs, ref_div(ra, rb, rs), "rand");
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
